rx_playout_buffer: RTL and testbench
====================================

Name: rx_playout_buffer

Overview:
Jitter/playout buffer between the serial receiver and the volume control/PDM output path. It accepts signed 8-bit audio bytes whenever the receiver reports a new code, which happens at irregular times. It stores them in a circular FIFO and replays them at the steady 12 kHz sample tick produced by the last decimation stage. A priming threshold absorbs link jitter; underflow and overflow are handled deterministically and reported.

Parameters:
DEPTH, 64, FIFO entries; power of two, >= 4
PRIME_LEVEL, 16, fill level required before playback starts/restarts; 1..DEPTH
SILENCE, 8'sd0, sample emitted while not playing or on underflow

Ports:
clk_in  input  1  system clock (98.3 MHz audio clock)
rst_in  input  1  reset, synchronous, active-low
byte_in  input  8  signed received audio byte
byte_valid_in  input  1  single-cycle strobe: byte_in valid
tick_in  input  1  single-cycle 12 kHz playout strobe
flush_in  input  1  single-cycle: discard contents, return to PRIMING
sample_out  output  8  signed playout sample, held between ticks
sample_valid_out  output  1  single-cycle strobe, one cycle after each tick_in
level_out  output  clog2(DEPTH)+1  current occupancy 0..DEPTH
underflow_out  output  1  single-cycle pulse: tick while PLAYING with FIFO empty
overflow_out  output  1  single-cycle pulse: byte dropped because FIFO full
state_out  output  1  0 = PRIMING, 1 = PLAYING

Behaviour:
- Reset (rst_in==0 at posedge): wr/rd pointers 0, level 0, state PRIMING, sample_out=SILENCE, sample_valid_out=0, underflow_out=0, overflow_out=0. Storage contents need not be cleared.
- Priority: reset > flush_in > normal operation. flush_in acts like reset for pointers/level/state/flags. sample_out holds its value. Any write or tick in the same cycle is ignored.
- Write: byte_valid_in && level<DEPTH -> store byte_in at wr_ptr, wr_ptr wraps at DEPTH.
- Write while full with no simultaneous pop -> byte dropped (newest lost), overflow_out=1 next cycle, pointers and level unchanged.
- Write while full with a simultaneous pop (PLAYING tick) -> both proceed, no overflow, level stays DEPTH.
- Pop: occurs only on tick_in in PLAYING with level>0. sample_out <= mem[rd_ptr] and rd_ptr wraps.
- Output latency: sample_out updates and sample_valid_out pulses exactly 1 cycle after tick_in, on every tick regardless of state.
- State PRIMING:
  - On tick, sample_out <= SILENCE and nothing is popped.
  - The transition to PLAYING is evaluated each cycle on the registered level: level >= PRIME_LEVEL -> PLAYING next cycle.
- State PLAYING:
  - On tick with level>0: pop.
  - On tick with level==0: sample_out <= SILENCE, underflow_out=1 next cycle, state -> PRIMING.
  - A write arriving in the same cycle as an empty tick is stored, but is not bypassed to the output.
- level_out: registered. +1 on accepted write, -1 on pop, unchanged when both occur. It never exceeds DEPTH and never goes below 0.
- Arithmetic: samples pass through unmodified (two's complement). No saturation or scaling.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then 15 byte writes (values 1..15) and 3 ticks -> state stays PRIMING, three sample_valid_out pulses each with sample_out=0, level_out=15.
2. Write a 16th byte (16) -> PLAYING next cycle. The next 16 ticks yield 1,2,...,16 in order, each valid 1 cycle after its tick. level_out steps down to 0.
3. Continuing from 2, one more tick -> sample_out=0, underflow_out one-cycle pulse, state PRIMING, level_out=0.
4. In PRIMING, write 64 bytes (0x80..0xBF), then a 65th (0x7F) -> overflow_out pulse, level_out=64. After playback starts, the sequence reads 0x80..0xBF and 0x7F never appears.
5. Full and PLAYING, byte_valid_in and tick_in in the same cycle -> no overflow, level_out stays 64, oldest byte output, new byte appears last. Also check pointer wrap by streaming 200 bytes through at matched rate.
6. Mid-playback (level 30), assert flush_in together with a tick and a write -> no sample_valid_out for that tick, level_out=0, state PRIMING. Separately, assert rst_in low mid-stream -> all outputs reach reset values on the next posedge.

Source files
------------

// File: rtl/rx_playout_buffer.sv
// Jitter/playout buffer: stores received audio bytes arriving at irregular times
// and replays them on the steady 12 kHz tick once a priming fill level is reached.
module rx_playout_buffer #(
   parameter int               DEPTH       = 64,
   parameter int               PRIME_LEVEL = 16,
   parameter logic signed [7:0] SILENCE    = 8'sd0
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [7:0]                byte_in,
   input  logic                      byte_valid_in,
   input  logic                      tick_in,
   input  logic                      flush_in,
   output logic [7:0]                sample_out,
   output logic                      sample_valid_out,
   output logic [$clog2(DEPTH):0]    level_out,
   output logic                      underflow_out,
   output logic                      overflow_out,
   output logic                      state_out
);

   // state      | meaning
   // ST_PRIMING | filling up, ticks emit SILENCE, nothing popped
   // ST_PLAYING | each tick pops one byte; empty tick -> underflow, back to priming

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      ST_PRIMING = 1'b0,
      ST_PLAYING = 1'b1
   } state_t;

   state_t          state_q, state_nxt;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level_q, level_nxt;
   logic            full, empty, pop, wr_accept;

   always_comb begin
      full      = (level_q == LW'(DEPTH));
      empty     = (level_q == '0);
      pop       = tick_in && (state_q == ST_PLAYING) && !empty;
      // a pop in the same cycle frees the slot the write needs
      wr_accept = byte_valid_in && (!full || pop);

      level_nxt = level_q;
      case ({wr_accept, pop})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase

      state_nxt = state_q;
      case (state_q)
         ST_PRIMING: if (level_q >= LW'(PRIME_LEVEL)) state_nxt = ST_PLAYING;
         ST_PLAYING: if (tick_in && empty)            state_nxt = ST_PRIMING;
         default:                                      state_nxt = ST_PRIMING;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in || flush_in) state_q <= ST_PRIMING;
      else                     state_q <= state_nxt;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         level_q          <= '0;
         sample_out       <= SILENCE;
         sample_valid_out <= 1'b0;
         underflow_out    <= 1'b0;
         overflow_out     <= 1'b0;
      end else if (flush_in) begin
         // sample_out deliberately holds its last value across a flush
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         level_q          <= '0;
         sample_valid_out <= 1'b0;
         underflow_out    <= 1'b0;
         overflow_out     <= 1'b0;
      end else begin
         level_q          <= level_nxt;
         sample_valid_out <= tick_in;
         underflow_out    <= tick_in && (state_q == ST_PLAYING) && empty;
         overflow_out     <= byte_valid_in && full && !pop;
         if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)       rd_ptr <= rd_ptr + AW'(1);
         if (tick_in)   sample_out <= pop ? mem[rd_ptr] : SILENCE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && !flush_in && wr_accept) mem[wr_ptr] <= byte_in;
   end

   assign level_out = level_q;
   assign state_out = (state_q == ST_PLAYING);

endmodule

// File: tb/tb_rx_playout_buffer.sv
// Directed bench for rx_playout_buffer: priming, playback, underflow, overflow,
// full-rate streaming across pointer wrap, flush and mid-stream reset.
module tb_rx_playout_buffer;

   localparam int DEPTH = 64;
   localparam int PRIME = 16;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_valid_in = 1'b0;
   logic       tick_in = 1'b0;
   logic       flush_in = 1'b0;
   logic [7:0] sample_out;
   logic       sample_valid_out;
   logic [6:0] level_out;
   logic       underflow_out;
   logic       overflow_out;
   logic       state_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] q [$];
   logic [7:0] b;
   logic [7:0] exp_s;
   logic [7:0] last_s;

   always #5 clk_in = ~clk_in;

   rx_playout_buffer #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .SILENCE(8'sd0)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .byte_in          (byte_in),
      .byte_valid_in    (byte_valid_in),
      .tick_in          (tick_in),
      .flush_in         (flush_in),
      .sample_out       (sample_out),
      .sample_valid_out (sample_valid_out),
      .level_out        (level_out),
      .underflow_out    (underflow_out),
      .overflow_out     (overflow_out),
      .state_out        (state_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one cycle of inputs from a negedge; returns at the next negedge
   task automatic cyc(input logic bv, input logic [7:0] bi, input logic tk, input logic fl);
      byte_valid_in = bv;
      byte_in       = bi;
      tick_in       = tk;
      flush_in      = fl;
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      tick_in       = 1'b0;
      flush_in      = 1'b0;
   endtask

   initial begin
      @(negedge clk_in);
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("rst_level", level_out, 0);
      chk("rst_state", state_out, 0);
      chk("rst_sample", sample_out, 0);
      chk("rst_valid", sample_valid_out, 0);
      chk("rst_uf", underflow_out, 0);
      chk("rst_of", overflow_out, 0);
      rst_in = 1'b1;

      // 1: 15 bytes, 3 ticks while priming
      for (int i = 1; i <= 15; i++) cyc(1, 8'(i), 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("prime_valid", sample_valid_out, 1);
         chk("prime_sample", sample_out, 0);
         chk("prime_state", state_out, 0);
      end
      chk("prime_level", level_out, 15);

      // 2: 16th byte starts playback
      cyc(1, 8'd16, 0, 0);
      chk("lvl16", level_out, 16);
      chk("state_lag", state_out, 0);
      cyc(0, 8'h00, 0, 0);
      chk("state_play", state_out, 1);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 8'h00, 1, 0);
         chk("play_valid", sample_valid_out, 1);
         chk("play_sample", sample_out, 32'(k));
         chk("play_level", level_out, 32'(16 - k));
         if (k == 1) begin
            cyc(0, 8'h00, 0, 0);
            chk("valid_pulse", sample_valid_out, 0);
            chk("sample_hold", sample_out, 1);
         end
      end

      // 3: underflow
      cyc(0, 8'h00, 1, 0);
      chk("uf_sample", sample_out, 0);
      chk("uf_pulse", underflow_out, 1);
      chk("uf_state", state_out, 0);
      chk("uf_level", level_out, 0);
      cyc(0, 8'h00, 0, 0);
      chk("uf_clear", underflow_out, 0);

      // 4: fill to 64 then one dropped byte
      for (int i = 0; i < 64; i++) cyc(1, 8'(8'h80 + i), 0, 0);
      chk("full_level", level_out, 64);
      chk("full_no_of", overflow_out, 0);
      cyc(1, 8'h7F, 0, 0);
      chk("of_pulse", overflow_out, 1);
      chk("of_level", level_out, 64);
      cyc(0, 8'h00, 0, 0);
      chk("of_clear", overflow_out, 0);
      chk("full_state", state_out, 1);

      // 5: write+tick while full
      cyc(1, 8'hC0, 1, 0);
      chk("wt_of", overflow_out, 0);
      chk("wt_level", level_out, 64);
      chk("wt_sample", sample_out, 8'h80);
      for (int i = 0; i < 63; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("drain_sample", sample_out, 32'(8'h81 + i));
      end
      cyc(0, 8'h00, 1, 0);
      chk("drain_last", sample_out, 8'hC0);
      chk("drain_level", level_out, 0);

      // 5b: matched-rate streaming over many pointer wraps
      for (int i = 0; i < PRIME; i++) begin
         b = 8'(8'hE0 + i);
         cyc(1, b, 0, 0);
         q.push_back(b);
      end
      cyc(0, 8'h00, 0, 0);
      chk("stream_state", state_out, 1);
      last_s = 8'h00;
      for (int i = 0; i < 200; i++) begin
         b = 8'(i * 7 + 3);
         cyc(1, b, 1, 0);
         q.push_back(b);
         exp_s  = q.pop_front();
         last_s = exp_s;
         chk("stream_sample", sample_out, exp_s);
         chk("stream_level", level_out, 16);
      end

      // 6: flush at level 30 with simultaneous tick and write
      for (int i = 0; i < 14; i++) cyc(1, 8'(i), 0, 0);
      chk("pre_flush_level", level_out, 30);
      cyc(1, 8'h55, 1, 1);
      chk("flush_valid", sample_valid_out, 0);
      chk("flush_level", level_out, 0);
      chk("flush_state", state_out, 0);
      chk("flush_hold", sample_out, last_s);
      for (int i = 0; i < PRIME; i++) cyc(1, 8'(8'h10 + i), 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("reprime_state", state_out, 1);
      cyc(0, 8'h00, 1, 0);
      chk("reprime_sample", sample_out, 8'h10);

      // mid-stream reset
      rst_in = 1'b0;
      cyc(1, 8'h33, 1, 0);
      chk("mrst_sample", sample_out, 0);
      chk("mrst_valid", sample_valid_out, 0);
      chk("mrst_level", level_out, 0);
      chk("mrst_state", state_out, 0);
      chk("mrst_uf", underflow_out, 0);
      chk("mrst_of", overflow_out, 0);
      rst_in = 1'b1;
      cyc(0, 8'h00, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
